aq_ifu_ibuf_queue: RTL and testbench
====================================

# aq_ifu_ibuf_queue

Parametrised multi-entry instruction buffer for the IFU. Each entry holds one 16-bit instruction halfword plus its prediction, exception and debug-halt attributes. The queue accepts up to FETCH_HW halfwords per cycle from the fetch stage and presents the two oldest entries to decode, which retires 0, 1 or 2 per cycle. It replaces the per-entry instantiation scheme with a single circular queue that has pointer arithmetic, occupancy tracking and backpressure.

## Interface
- DEPTH, 16, number of halfword entries; power of two, at least 2*FETCH_HW.
- FETCH_HW, 4, maximum halfwords pushed per cycle; power of two.
- HINFO_W, 22, width of halt info.
- CNT_W, log2(DEPTH)+1, width of the occupancy count (derived).
- ibuf_cpuclk  in  1  clock.
- cpurst_b  in  1  reset, asynchronous, active-low.
- ibuf_flush_en  in  1  discard all contents.
- ibuf_push_vld  in  1  push request.
- ibuf_push_cnt  in  log2(FETCH_HW)+1  number of halfwords to push, 1..FETCH_HW.
- ibuf_push_inst  in  16*FETCH_HW  halfwords, packed oldest at [15:0].
- ibuf_push_pred_taken  in  2*FETCH_HW  per-halfword prediction, packed the same way.
- ibuf_push_acc_err  in  1  bus access error, shared by the whole group.
- ibuf_push_pgflt  in  1  page fault, shared by the whole group.
- ibuf_push_halt_info  in  HINFO_W  halt info, shared by the whole group.
- ibuf_push_rdy  out  1  room for FETCH_HW entries.
- ibuf_pop_cnt  in  2  number of entries retired this cycle (0..2).
- ibuf_pop_vld  out  2  bit i set means output slot i holds a valid entry.
- ibuf_pop_inst0 / ibuf_pop_inst1  out  16  head / head+1 halfword.
- ibuf_pop_pred_taken0 / ibuf_pop_pred_taken1  out  2  prediction for each slot.
- ibuf_pop_acc_err  out  2  access error per slot.
- ibuf_pop_pgflt  out  2  page fault per slot.
- ibuf_pop_halt_info0 / ibuf_pop_halt_info1  out  HINFO_W  halt info per slot.
- ibuf_entry_cnt  out  CNT_W  current occupancy.

## Operation
- State:
  - wr_ptr, rd_ptr: log2(DEPTH) bits each, wrapping modulo DEPTH.
  - entry_cnt: CNT_W bits, range 0..DEPTH.
  - Data array of DEPTH entries, each holding inst, pred_taken, acc_err, pgflt and halt_info.
- Reset and flush:
  - Only the pointers and the count are reset; the data array is not.
  - On reset, pointers and count go to 0.
- Push acceptance: push_acc = ibuf_push_vld & ibuf_push_rdy & ~ibuf_flush_en.
  - Halfword k (k < ibuf_push_cnt) is written to entry (wr_ptr+k) mod DEPTH.
  - Shared acc_err, pgflt and halt_info are copied into every entry written.
  - Entries at k >= ibuf_push_cnt are not written.
- ibuf_push_rdy = (DEPTH - entry_cnt) >= FETCH_HW.
  - Computed from the registered count only; a same-cycle pop does not raise it.
  - With push_vld high and push_rdy low, nothing is written and the request is held upstream.
- Pop: pop_eff = min(ibuf_pop_cnt, entry_cnt).
  - An ibuf_pop_cnt larger than entry_cnt is illegal; the bench flags it, and RTL clips it to pop_eff.
  - pop_cnt = 3 is illegal and is treated as 2.
- Output slots:
  - Slot 0 = entry[rd_ptr]; slot 1 = entry[(rd_ptr+1) mod DEPTH].
  - ibuf_pop_vld[0] = entry_cnt >= 1; ibuf_pop_vld[1] = entry_cnt >= 2.
  - Every slot data field is forced to 0 when that slot's vld bit is 0.
- Update, when no flush:
  - wr_ptr += push_acc ? push_cnt : 0.
  - rd_ptr += pop_eff.
  - entry_cnt += pushed - pop_eff.
- Flush (highest priority):
  - wr_ptr, rd_ptr and entry_cnt go to 0.
  - Any same-cycle push and pop are ignored.
- ibuf_entry_cnt = entry_cnt.

## Timing
- Values after reset:
  - ibuf_pop_vld = 2'b00, ibuf_entry_cnt = 0, ibuf_push_rdy = 1.
  - All pop data outputs are 0.
- Push-to-pop latency is 1 cycle. Data pushed at edge N appears on the slot outputs after edge N; there is no same-cycle bypass.
- Simultaneous push and pop are both applied at the same edge; the net count is the sum of the two changes.
- Wrap-around: pushes and pops crossing index DEPTH-1 continue at index 0 without a bubble.
- Full (entry_cnt = DEPTH): push_rdy = 0; pops proceed normally.
- Empty: pop_vld = 0; the pop request is clipped to 0.
- Reset asserted mid-operation: all state clears immediately. Outputs take their reset values while reset is asserted, and remain there until the first accepted push after release.
- Flush in the same cycle as reset release: the queue stays empty.

## Test plan
- Reset, then push {0x1111,0x2222,0x3333,0x4444} with cnt 4 -> next cycle: pop_vld = 11, inst0 = 0x1111, inst1 = 0x2222, entry_cnt = 4.
- Push 4 per cycle for 4 cycles with no pops (DEPTH 16) -> entry_cnt = 16, push_rdy = 0. Then a fifth push -> ignored; entry_cnt stays 16.
- Pop 2 per cycle from a full queue while pushing 4 whenever push_rdy is set, for 20 cycles -> pointers wrap, FIFO order is preserved with data matching the scoreboard, and the count never exceeds 16.
- Push cnt 3 with acc_err = 1 and halt_info = 0x2AAAAA -> the three entries carry acc_err = 1 and that halt_info; the slot after them (wr_ptr+3) is unaffected.
- Flush asserted together with a push of 4 and a pop of 2 while entry_cnt = 7 -> next cycle: entry_cnt = 0, pop_vld = 00, all data outputs are 0.
- entry_cnt = 1 with pop_cnt = 2 -> count goes to 0 with no underflow (the bench flags the illegal request). Reset asserted mid-stream -> pop_vld = 00 asynchronously and push_rdy = 1.

Source files
------------

// File: rtl/aq_ifu_ibuf_queue.sv
// rtl/aq_ifu_ibuf_queue.sv - circular instruction halfword buffer between fetch and decode
module aq_ifu_ibuf_queue #(
    parameter int DEPTH    = 16,
    parameter int FETCH_HW = 4,
    parameter int HINFO_W  = 22,
    parameter int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                        ibuf_cpuclk,
    input  logic                        cpurst_b,
    input  logic                        ibuf_flush_en,
    input  logic                        ibuf_push_vld,
    input  logic [$clog2(FETCH_HW):0]   ibuf_push_cnt,
    input  logic [16*FETCH_HW-1:0]      ibuf_push_inst,
    input  logic [2*FETCH_HW-1:0]       ibuf_push_pred_taken,
    input  logic                        ibuf_push_acc_err,
    input  logic                        ibuf_push_pgflt,
    input  logic [HINFO_W-1:0]          ibuf_push_halt_info,
    output logic                        ibuf_push_rdy,
    input  logic [1:0]                  ibuf_pop_cnt,
    output logic [1:0]                  ibuf_pop_vld,
    output logic [15:0]                 ibuf_pop_inst0,
    output logic [15:0]                 ibuf_pop_inst1,
    output logic [1:0]                  ibuf_pop_pred_taken0,
    output logic [1:0]                  ibuf_pop_pred_taken1,
    output logic [1:0]                  ibuf_pop_acc_err,
    output logic [1:0]                  ibuf_pop_pgflt,
    output logic [HINFO_W-1:0]          ibuf_pop_halt_info0,
    output logic [HINFO_W-1:0]          ibuf_pop_halt_info1,
    output logic [CNT_W-1:0]            ibuf_entry_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int PC_W  = $clog2(FETCH_HW) + 1;

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   rd_ptr1;
    logic [CNT_W-1:0]   entry_cnt;

    logic [15:0]        mem_inst [DEPTH];
    logic [1:0]         mem_pt   [DEPTH];
    logic               mem_ae   [DEPTH];
    logic               mem_pf   [DEPTH];
    logic [HINFO_W-1:0] mem_hi   [DEPTH];

    logic               push_acc;
    logic [CNT_W-1:0]   push_num;
    logic [CNT_W-1:0]   pop_req;
    logic [CNT_W-1:0]   pop_eff;

    // Readiness looks only at the registered count so it never depends on decode's pop
    assign ibuf_push_rdy = (entry_cnt <= CNT_W'(DEPTH - FETCH_HW));
    assign push_acc      = ibuf_push_vld & ibuf_push_rdy & ~ibuf_flush_en;

    always_comb begin
        push_num = '0;
        if (push_acc) begin
            push_num = (ibuf_push_cnt > PC_W'(FETCH_HW)) ? CNT_W'(FETCH_HW) : CNT_W'(ibuf_push_cnt);
        end
        pop_req = (ibuf_pop_cnt == 2'd3) ? CNT_W'(2) : CNT_W'(ibuf_pop_cnt);
        pop_eff = (pop_req > entry_cnt) ? entry_cnt : pop_req;
    end

    always_ff @(posedge ibuf_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            entry_cnt <= '0;
        end else if (ibuf_flush_en) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            entry_cnt <= '0;
        end else begin
            wr_ptr    <= wr_ptr + push_num[PTR_W-1:0];
            rd_ptr    <= rd_ptr + pop_eff[PTR_W-1:0];
            entry_cnt <= entry_cnt + push_num - pop_eff;
        end
    end

    // Payload storage carries no reset; validity comes solely from entry_cnt
    always_ff @(posedge ibuf_cpuclk) begin
        for (int k = 0; k < FETCH_HW; k++) begin
            if (push_acc && (CNT_W'(k) < push_num)) begin
                mem_inst[wr_ptr + PTR_W'(k)] <= ibuf_push_inst[16*k +: 16];
                mem_pt[wr_ptr + PTR_W'(k)]   <= ibuf_push_pred_taken[2*k +: 2];
                mem_ae[wr_ptr + PTR_W'(k)]   <= ibuf_push_acc_err;
                mem_pf[wr_ptr + PTR_W'(k)]   <= ibuf_push_pgflt;
                mem_hi[wr_ptr + PTR_W'(k)]   <= ibuf_push_halt_info;
            end
        end
    end

    assign rd_ptr1         = rd_ptr + PTR_W'(1);
    assign ibuf_pop_vld[0] = (entry_cnt != '0);
    assign ibuf_pop_vld[1] = (entry_cnt >= CNT_W'(2));

    assign ibuf_pop_inst0       = ibuf_pop_vld[0] ? mem_inst[rd_ptr]  : '0;
    assign ibuf_pop_inst1       = ibuf_pop_vld[1] ? mem_inst[rd_ptr1] : '0;
    assign ibuf_pop_pred_taken0 = ibuf_pop_vld[0] ? mem_pt[rd_ptr]    : '0;
    assign ibuf_pop_pred_taken1 = ibuf_pop_vld[1] ? mem_pt[rd_ptr1]   : '0;
    assign ibuf_pop_halt_info0  = ibuf_pop_vld[0] ? mem_hi[rd_ptr]    : '0;
    assign ibuf_pop_halt_info1  = ibuf_pop_vld[1] ? mem_hi[rd_ptr1]   : '0;
    assign ibuf_pop_acc_err     = {ibuf_pop_vld[1] & mem_ae[rd_ptr1], ibuf_pop_vld[0] & mem_ae[rd_ptr]};
    assign ibuf_pop_pgflt       = {ibuf_pop_vld[1] & mem_pf[rd_ptr1], ibuf_pop_vld[0] & mem_pf[rd_ptr]};
    assign ibuf_entry_cnt       = entry_cnt;

endmodule

// File: tb/tb_aq_ifu_ibuf_queue.sv
// tb/tb_aq_ifu_ibuf_queue.sv - randomized scoreboard bench for aq_ifu_ibuf_queue
module tb_aq_ifu_ibuf_queue;

    localparam int DEPTH = 16;
    localparam int FH    = 4;
    localparam int HW    = 22;
    localparam int CW    = 5;
    localparam int VW    = 2 + 16 + 16 + 2 + 2 + 2 + 2 + HW + HW + CW + 1;

    typedef struct packed {
        logic [15:0]   inst;
        logic [1:0]    pt;
        logic          ae;
        logic          pf;
        logic [HW-1:0] hi;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          flush;
    logic          push_vld;
    logic [2:0]    push_cnt;
    logic [63:0]   push_inst;
    logic [7:0]    push_pt;
    logic          push_ae;
    logic          push_pf;
    logic [HW-1:0] push_hi;
    logic          push_rdy;
    logic [1:0]    pop_cnt;
    logic [1:0]    pop_vld;
    logic [15:0]   inst0, inst1;
    logic [1:0]    pt0, pt1;
    logic [1:0]    pop_ae, pop_pf;
    logic [HW-1:0] hi0, hi1;
    logic [CW-1:0] ecnt;
    logic [VW-1:0] act;

    ent_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    aq_ifu_ibuf_queue #(.DEPTH(DEPTH), .FETCH_HW(FH), .HINFO_W(HW)) dut (
        .ibuf_cpuclk          (clk),
        .cpurst_b             (rst_b),
        .ibuf_flush_en        (flush),
        .ibuf_push_vld        (push_vld),
        .ibuf_push_cnt        (push_cnt),
        .ibuf_push_inst       (push_inst),
        .ibuf_push_pred_taken (push_pt),
        .ibuf_push_acc_err    (push_ae),
        .ibuf_push_pgflt      (push_pf),
        .ibuf_push_halt_info  (push_hi),
        .ibuf_push_rdy        (push_rdy),
        .ibuf_pop_cnt         (pop_cnt),
        .ibuf_pop_vld         (pop_vld),
        .ibuf_pop_inst0       (inst0),
        .ibuf_pop_inst1       (inst1),
        .ibuf_pop_pred_taken0 (pt0),
        .ibuf_pop_pred_taken1 (pt1),
        .ibuf_pop_acc_err     (pop_ae),
        .ibuf_pop_pgflt       (pop_pf),
        .ibuf_pop_halt_info0  (hi0),
        .ibuf_pop_halt_info1  (hi1),
        .ibuf_entry_cnt       (ecnt)
    );

    assign act = {pop_vld, inst0, inst1, pt0, pt1, pop_ae, pop_pf, hi0, hi1, ecnt, push_rdy};

    function automatic logic [VW-1:0] exp_vec();
        ent_t e0 = '0;
        ent_t e1 = '0;
        logic [1:0] v = 2'b00;
        if (q.size() >= 1) begin e0 = q[0]; v[0] = 1'b1; end
        if (q.size() >= 2) begin e1 = q[1]; v[1] = 1'b1; end
        return {v, e0.inst, e1.inst, e0.pt, e1.pt, {e1.ae, e0.ae}, {e1.pf, e0.pf},
                e0.hi, e1.hi, CW'(q.size()), (DEPTH - q.size()) >= FH};
    endfunction

    // Queue-level model: retire min(request, occupancy), then append the group if room existed
    task automatic model_apply();
        int   sz;
        int   req;
        int   pe;
        ent_t e;
        sz = q.size();
        if (!rst_b || flush) begin
            q.delete();
        end else begin
            req = (pop_cnt == 2'd3) ? 2 : int'(pop_cnt);
            if (int'(pop_cnt) > sz || pop_cnt == 2'd3)
                $display("note: illegal pop request %0d with %0d entries, clipped", pop_cnt, sz);
            pe = (req < sz) ? req : sz;
            repeat (pe) void'(q.pop_front());
            if (push_vld && (DEPTH - sz) >= FH) begin
                for (int k = 0; k < int'(push_cnt); k++) begin
                    e.inst = push_inst[16*k +: 16];
                    e.pt   = push_pt[2*k +: 2];
                    e.ae   = push_ae;
                    e.pf   = push_pf;
                    e.hi   = push_hi;
                    q.push_back(e);
                end
            end
        end
    endtask

    task automatic step();
        model_apply();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        flush    = 1'b0;
        push_vld = 1'b0;
        push_cnt = 3'd0;
        pop_cnt  = 2'd0;
        push_ae  = 1'b0;
        push_pf  = 1'b0;
        push_hi  = '0;
    endtask

    task automatic rand_group(input int cnt);
        push_vld  = 1'b1;
        push_cnt  = 3'(cnt);
        push_inst = {$urandom, $urandom};
        push_pt   = 8'($urandom);
        push_ae   = 1'($urandom);
        push_pf   = 1'($urandom);
        push_hi   = HW'($urandom);
    endtask

    task automatic do_flush();
        set_idle();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        push_inst = '0;
        push_pt   = '0;
        rst_b     = 1'b0;
        #12;
        q.delete();
        n_chk++;
        if (act !== exp_vec()) $display("FAIL reset_state act=%h exp=%h", act, exp_vec());
        else n_pass++;
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        step();
        n_chk++;
        if ({pop_vld, ecnt, push_rdy} !== {2'b00, 5'd0, 1'b1})
            $display("FAIL reset_release act=%b/%0d/%b exp=00/0/1", pop_vld, ecnt, push_rdy);
        else n_pass++;
    endtask

    task automatic test_basic_push();
        set_idle();
        push_vld  = 1'b1;
        push_cnt  = 3'd4;
        push_inst = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        push_pt   = 8'h1B;
        step();
        set_idle();
        n_chk++;
        if ({pop_vld, inst0, inst1, ecnt} !== {2'b11, 16'h1111, 16'h2222, 5'd4})
            $display("FAIL basic_push act=%b %h %h %0d exp=11 1111 2222 4", pop_vld, inst0, inst1, ecnt);
        else n_pass++;
        n_chk++;
        if (act !== exp_vec()) $display("FAIL basic_model act=%h exp=%h", act, exp_vec());
        else n_pass++;
    endtask

    task automatic test_fill();
        do_flush();
        for (int i = 0; i < 4; i++) begin
            rand_group(4);
            step();
            n_chk++;
            if (act !== exp_vec()) $display("FAIL fill_%0d act=%h exp=%h", i, act, exp_vec());
            else n_pass++;
        end
        n_chk++;
        if ({ecnt, push_rdy} !== {5'd16, 1'b0})
            $display("FAIL full_state act=%0d/%b exp=16/0", ecnt, push_rdy);
        else n_pass++;
        rand_group(4);
        step();
        set_idle();
        n_chk++;
        if (ecnt !== 5'd16) $display("FAIL push_when_full act=%0d exp=16", ecnt);
        else n_pass++;
    endtask

    task automatic test_wrap_stream();
        for (int i = 0; i < 20; i++) begin
            set_idle();
            pop_cnt = 2'd2;
            if ((DEPTH - q.size()) >= FH) rand_group(4);
            step();
            n_chk++;
            if (act !== exp_vec() || ecnt > 5'd16)
                $display("FAIL wrap_%0d act=%h exp=%h", i, act, exp_vec());
            else n_pass++;
        end
        set_idle();
    endtask

    task automatic test_shared_attrs();
        do_flush();
        rand_group(2);
        step();
        set_idle();
        pop_cnt = 2'd2;
        step();
        rand_group(3);
        push_ae   = 1'b1;
        push_pf   = 1'b0;
        push_hi   = 22'h2AAAAA;
        push_inst = {16'hDEAD, 16'h0C03, 16'h0B02, 16'h0A01};
        step();
        set_idle();
        n_chk++;
        if ({ecnt, pop_ae, hi0, hi1, inst0} !== {5'd3, 2'b11, 22'h2AAAAA, 22'h2AAAAA, 16'h0A01})
            $display("FAIL shared_attrs act=%0d %b %h %h %h", ecnt, pop_ae, hi0, hi1, inst0);
        else n_pass++;
        pop_cnt = 2'd2;
        step();
        set_idle();
        n_chk++;
        if (act !== exp_vec()) $display("FAIL shared_tail act=%h exp=%h", act, exp_vec());
        else n_pass++;
    endtask

    task automatic test_flush();
        do_flush();
        rand_group(4);
        step();
        rand_group(3);
        step();
        set_idle();
        n_chk++;
        if (ecnt !== 5'd7) $display("FAIL flush_pre act=%0d exp=7", ecnt);
        else n_pass++;
        rand_group(4);
        pop_cnt = 2'd2;
        flush   = 1'b1;
        step();
        set_idle();
        n_chk++;
        if (act !== {2'b00, {(VW - 8){1'b0}}, 5'd0, 1'b1})
            $display("FAIL flush_clear act=%h exp=empty", act);
        else n_pass++;
    endtask

    task automatic test_underflow();
        do_flush();
        rand_group(1);
        step();
        set_idle();
        pop_cnt = 2'd2;
        step();
        set_idle();
        n_chk++;
        if ({pop_vld, ecnt} !== {2'b00, 5'd0}) $display("FAIL underflow act=%b/%0d exp=00/0", pop_vld, ecnt);
        else n_pass++;
        rand_group(4);
        step();
        set_idle();
        pop_cnt = 2'd3;
        step();
        set_idle();
        n_chk++;
        if (ecnt !== 5'd2 || act !== exp_vec()) $display("FAIL pop_three act=%h exp=%h", act, exp_vec());
        else n_pass++;
    endtask

    task automatic test_random();
        int lim;
        for (int i = 0; i < 200; i++) begin
            set_idle();
            if ($urandom_range(0, 1) == 1) rand_group(int'($urandom_range(1, FH)));
            lim     = (q.size() < 2) ? q.size() : 2;
            pop_cnt = 2'($urandom_range(0, lim));
            flush   = ($urandom_range(0, 39) == 0);
            step();
            n_chk++;
            if (act !== exp_vec()) $display("FAIL random_%0d act=%h exp=%h", i, act, exp_vec());
            else n_pass++;
        end
        set_idle();
    endtask

    task automatic test_reset_mid();
        rand_group(4);
        step();
        rand_group(4);
        step();
        rand_group(3);
        #2;
        rst_b = 1'b0;
        #1;
        n_chk++;
        if ({pop_vld, push_rdy, ecnt} !== {2'b00, 1'b1, 5'd0})
            $display("FAIL reset_async act=%b/%b/%0d exp=00/1/0", pop_vld, push_rdy, ecnt);
        else n_pass++;
        @(posedge clk);
        #1;
        q.delete();
        step();
        n_chk++;
        if (act !== exp_vec()) $display("FAIL reset_hold act=%h exp=%h", act, exp_vec());
        else n_pass++;
        flush = 1'b1;
        rst_b = 1'b1;
        step();
        set_idle();
        step();
        n_chk++;
        if (act !== exp_vec() || ecnt !== 5'd0)
            $display("FAIL release_flush act=%h exp=%h", act, exp_vec());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_push();
        test_fill();
        test_wrap_stream();
        test_shared_attrs();
        test_flush();
        test_underflow();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
